// File: rtl/alu_exec.sv
// ============================================================================
// Module      : alu_exec
// Description : Handshaked 32-bit ALU; shifts run iteratively, SHIFT_STEP bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ALUResult,
    output logic        Zero
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [1:0] c_SLL = 2'd0;
    localparam logic [1:0] c_SRL = 2'd1;
    localparam logic [1:0] c_SRA = 2'd2;

    localparam logic [4:0] c_STEP = 5'(SHIFT_STEP);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_shreg;
    logic [4:0]  r_count;
    logic [1:0]  r_kind;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_is_shift;
    logic [4:0]  w_amt;
    logic [31:0] w_alu;
    logic [4:0]  w_step;
    logic [4:0]  w_count_nxt;
    logic [31:0] w_shifted;

    assign in_ready   = (r_state == c_IDLE) & ~rst;
    assign out_valid  = (r_state == c_DONE);
    assign ALUResult  = r_result;
    assign Zero       = (r_result == 32'd0);

    assign w_accept   = in_valid & in_ready;
    assign w_amt      = SrcB[4:0];
    assign w_is_shift = (ALUControl == 4'b0110) || (ALUControl == 4'b1001) ||
                        (ALUControl == 4'b1010);

    // Shift codes yield SrcA here, which is the correct zero-amount result.
    always_comb begin
        w_alu = SrcA + SrcB;
        case (ALUControl)
            4'b0001: w_alu = SrcA - SrcB;
            4'b0010: w_alu = SrcA & SrcB;
            4'b0011: w_alu = SrcA | SrcB;
            4'b0101: w_alu = {31'd0, $signed(SrcA) < $signed(SrcB)};
            4'b0110,
            4'b1001,
            4'b1010: w_alu = SrcA;
            default: w_alu = SrcA + SrcB;
        endcase
    end

    assign w_step      = (r_count < c_STEP) ? r_count : c_STEP;
    assign w_count_nxt = r_count - w_step;

    always_comb begin
        w_shifted = r_shreg << w_step;
        case (r_kind)
            c_SRL:   w_shifted = r_shreg >> w_step;
            c_SRA:   w_shifted = $unsigned($signed(r_shreg) >>> w_step);
            default: w_shifted = r_shreg << w_step;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)
                         w_state_nxt = (w_is_shift && (w_amt != 5'd0)) ? c_SHIFT : c_DONE;
            c_SHIFT: if (w_count_nxt == 5'd0) w_state_nxt = c_DONE;
            c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg  <= 32'd0;
            r_count  <= 5'd0;
            r_kind   <= c_SLL;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: if (w_accept) begin
                    if (w_is_shift && (w_amt != 5'd0)) begin
                        r_shreg <= SrcA;
                        r_count <= w_amt;
                        r_kind  <= ALUControl[3] ? (ALUControl[1] ? c_SRA : c_SRL) : c_SLL;
                    end else begin
                        r_result <= w_alu;
                    end
                end
                c_SHIFT: begin
                    r_shreg <= w_shifted;
                    r_count <= w_count_nxt;
                    if (w_count_nxt == 5'd0) r_result <= w_shifted;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001: Parameter SHIFT_STEP, default 1, bits shifted per cycle by the iterative shifter; legal range 1..31.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: in_valid  input  1  upstream presents an operation.
REQ-005: in_ready  output  1  block can accept an operation.
REQ-006: ALUControl  input  4  operation code from the ALU decoder.
REQ-007: SrcA  input  32  operand A.
REQ-008: SrcB  input  32  operand B; bits [4:0] are the shift amount for shifts.
REQ-009: out_valid  output  1  ALUResult/Zero hold a completed result.
REQ-010: out_ready  input  1  downstream consumes the result.
REQ-011: ALUResult  output  32  registered result.
REQ-012: Zero  output  1  high iff ALUResult == 0.

Function
REQ-013: Op codes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT (signed, result 0 or 1), 0110 SLL, 1001 SRL, 1010 SRA (sign fill); every other code SHALL execute as ADD.
REQ-014: Arithmetic SHALL be 32-bit modulo 2^32; no overflow or carry output; SrcB[31:5] ignored for shifts.
REQ-015: FSM states SHALL be IDLE, SHIFT, DONE; in_ready = 1 only in IDLE and not in reset.
REQ-016: Acceptance SHALL occur on a rising edge with in_valid & in_ready; SrcA, SrcB, ALUControl captured then; later input changes have no effect.
REQ-017: Non-shift op, or shift with SrcB[4:0] == 0: IDLE -> DONE at the acceptance edge; result visible the following cycle (latency 1); a zero-amount shift returns SrcA.
REQ-018: Shift with amount n > 0: IDLE -> SHIFT at acceptance, loading shift register = SrcA and count = n.
REQ-019: Each edge in SHIFT SHALL shift by step = min(count, SHIFT_STEP) in the op's direction/fill and decrement count by step; the edge where count reaches 0 moves to DONE.
REQ-020: Shift latency SHALL be 1 + ceil(n / SHIFT_STEP) cycles from the acceptance cycle to the first out_valid cycle.
REQ-021: In DONE, out_valid = 1; ALUResult and Zero SHALL hold stable until an edge with out_ready = 1, which moves to IDLE and deasserts out_valid.
REQ-022: No acceptance SHALL occur in SHIFT or DONE; in_valid there is ignored, and in_ready rises the cycle after the output handshake (minimum 2 cycles per op).
REQ-023: ALUResult SHALL change only on the edge entering DONE and on reset.
REQ-024: out_ready outside DONE SHALL have no effect.

Reset
REQ-025: rst = 1 SHALL immediately, without a clock edge, force state IDLE, count 0, ALUResult 0x00000000, Zero 1, out_valid 0, in_ready 0.
REQ-026: On the first rising edge after rst falls, the block SHALL be in IDLE with in_ready = 1.
REQ-027: Reset asserted in SHIFT or DONE SHALL discard the in-flight operation with no result delivered.

Verification
REQ-028: ADD, SrcA 0x7FFFFFFF, SrcB 0x00000001 -> next cycle out_valid 1, ALUResult 0x80000000, Zero 0.
REQ-029: SUB 5 - 5 -> ALUResult 0, Zero 1; SLT SrcA 0xFFFFFFFF, SrcB 1 -> ALUResult 1; code 1111 with 2 + 3 -> 5.
REQ-030: SHIFT_STEP 1, SRA SrcA 0x80000000, SrcB 0x24 (amount 4) -> in_ready 0 for 5 cycles, out_valid on cycle 5, ALUResult 0xF8000000; SHIFT_STEP 8, SRL 0xFFFFFFFF by 31 -> latency 5, result 0x00000001.
REQ-031: Result ready, out_ready held 0 for 3 cycles -> ALUResult and out_valid stable all 3 cycles; SrcA changed meanwhile has no effect; out_ready 1 -> out_valid 0 and in_ready 1 next cycle.
REQ-032: rst pulsed mid-way through a 20-bit SLL -> out_valid 0 and ALUResult 0 without a clock edge; after release, a new ADD 1 + 1 returns 2 with latency 1.
REQ-033: SLL by 0, SrcA 0x12345678 -> latency 1, ALUResult 0x12345678.
